// File: rtl/text_console_writer_if.sv
// Character stream in, text RAM write port and cursor/scroll state out, for the
// 800x600 text console writer.
interface text_console_writer_if #(
  parameter int ADDR_W = 12
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [6:0]        cursor_col;
  logic [5:0]        cursor_row;
  logic [5:0]        top_row;

  // Character source and display scan side.
  modport master (
    output char_valid, char_data,
    input  char_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, top_row
  );

  // The console writer itself.
  modport slave (
    input  char_valid, char_data,
    output char_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, top_row
  );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: turns an ASCII byte stream into text RAM writes, tracking the
// cursor, line wrap, control codes and circular-buffer hardware scrolling.
module text_console_writer #(
  parameter int COLS   = 100,
  parameter int ROWS   = 37,
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  text_console_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SCROLL_CLR = 2'd1,
    FF_CLR     = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_SCROLL = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CLR    = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        LAST_COL    = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW    = 6'(ROWS - 1);
  localparam logic [6:0]        ROWS_W      = 7'(ROWS);
  localparam logic [7:0]        SPACE       = 8'h20;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q,   ready_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [6:0]        col_q,     col_d;
  logic [5:0]        row_q,     row_d;
  logic [5:0]        top_q,     top_d;

  logic [6:0]        row_sum;
  logic [5:0]        phys_row;
  logic [5:0]        top_next;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] top_base;
  logic              printable;
  logic              do_newline;

  // Screen row to RAM row: the sum is below 2*ROWS, so one conditional subtract wraps it.
  always_comb begin
    row_sum   = {1'b0, top_q} + {1'b0, row_q};
    phys_row  = (row_sum >= ROWS_W) ? 6'(row_sum - ROWS_W) : row_sum[5:0];
    top_next  = (top_q == LAST_ROW) ? 6'd0 : top_q + 6'd1;
    line_base = ADDR_W'(phys_row) * COLS_A;
    top_base  = ADDR_W'(top_q) * COLS_A;
    printable = (bus.char_data >= 8'h20) && (bus.char_data <= 8'h7E);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FF_CLR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= SPACE;
      col_q     <= '0;
      row_q     <= '0;
      top_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      col_q     <= col_d;
      row_q     <= row_d;
      top_q     <= top_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that skipped one
  // would infer a latch. wr_addr/wr_data default to hold, wr_en to idle-low.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    ready_d    = ready_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    col_d      = col_q;
    row_d      = row_q;
    top_d      = top_q;
    do_newline = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.char_valid && ready_q) begin
          if (printable) begin
            wr_en_d   = 1'b1;
            wr_addr_d = line_base + ADDR_W'(col_q);
            wr_data_d = bus.char_data;
            if (col_q < LAST_COL) begin
              col_d = col_q + 7'd1;
            end else begin
              col_d      = '0;
              do_newline = 1'b1;
            end
          end else begin
            case (bus.char_data)
              CH_LF: begin
                col_d      = '0;
                do_newline = 1'b1;
              end
              CH_CR: col_d = '0;
              CH_BS: begin
                if (col_q != 7'd0) begin
                  col_d     = col_q - 7'd1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = line_base + ADDR_W'(col_q - 7'd1);
                  wr_data_d = SPACE;
                end
              end
              CH_FF: begin
                state_d   = FF_CLR;
                clr_cnt_d = '0;
                ready_d   = 1'b0;
                col_d     = '0;
                row_d     = '0;
              end
              default: ;
            endcase
          end

          // At the bottom row the cursor stays put and the oldest line is recycled.
          if (do_newline) begin
            if (row_q < LAST_ROW) begin
              row_d = row_q + 6'd1;
            end else begin
              state_d   = SCROLL_CLR;
              clr_cnt_d = '0;
              ready_d   = 1'b0;
            end
          end
        end
      end

      SCROLL_CLR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = top_base + clr_cnt_q;
        wr_data_d = SPACE;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_SCROLL) begin
          top_d     = top_next;
          clr_cnt_d = '0;
          state_d   = IDLE;
          ready_d   = 1'b1;
        end
      end

      FF_CLR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = SPACE;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_CLR) begin
          col_d     = '0;
          row_d     = '0;
          top_d     = '0;
          clr_cnt_d = '0;
          state_d   = IDLE;
          ready_d   = 1'b1;
        end
      end

      default: begin
        state_d   = FF_CLR;
        clr_cnt_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  assign bus.char_ready = ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.top_row    = top_q;

endmodule
